// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// A write request is a destination register plus its data.
package rf_arb_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_AUX  = 2'd2
    } grant_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Aux write buffer: circular FIFO of write requests.
// It exposes per-entry valid/addr so the arbiter can build the pending mask and the WAW compare.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  wr_req_t                            push_req,
    input  logic                               pop,
    output wr_req_t                            head,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(DEPTH):0]             count,
    output logic [DEPTH-1:0]                   ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic [DEPTH-1:0] valid;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            valid  <= '0;
        end else begin
            // push and pop never target the same slot: that needs full or empty
            if (do_push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = mem[i].addr;
        end
    end

    assign head      = mem[rd_ptr];
    assign count     = cnt;
    assign ent_valid = valid;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the single register-file write port between pipeline writeback and a buffered aux writer.
// Aux writes fill idle slots; starvation or a WAW hazard stalls the pipeline to force a drain.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_we,
    input  logic [REG_ADDR_W-1:0]   pipe_addr,
    input  logic [DATA_W-1:0]       pipe_data,
    output logic                    pipe_stall,
    input  logic                    aux_valid,
    input  logic [REG_ADDR_W-1:0]   aux_addr,
    input  logic [DATA_W-1:0]       aux_data,
    output logic                    aux_ready,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]       rf_data,
    output logic [15:0]             pend_mask,
    output logic [$clog2(DEPTH):0]  aux_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wr_req_t                           head;
    wr_req_t                           push_req;
    logic                              full;
    logic                              empty;
    logic [DEPTH-1:0]                  ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr;
    logic                              push;
    logic                              pop;
    logic                              pipe_live;
    logic                              waw_hit;
    logic                              starve_hit;
    logic [SW-1:0]                     starve_cnt;
    grant_t                            grant;

    // R0 is hardwired zero, so aux writes to it are acknowledged but dropped
    assign push     = aux_valid && !full && (aux_addr != '0);
    assign push_req = '{addr: aux_addr, data: aux_data};
    assign pop      = (grant == GNT_AUX);

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_req  (push_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (aux_cnt),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    assign aux_ready  = !full;
    assign pipe_live  = pipe_we && (pipe_addr != '0);
    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        waw_hit   = 1'b0;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pend_mask[ent_addr[i]] = 1'b1;
                if (ent_addr[i] == pipe_addr) waw_hit = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
        waw_hit      = waw_hit && pipe_live;
    end

    always_comb begin
        pipe_stall = !empty && (starve_hit || waw_hit);
        grant      = GNT_NONE;
        if (pipe_stall)     grant = GNT_AUX;
        else if (pipe_live) grant = GNT_PIPE;
        else if (!empty)    grant = GNT_AUX;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            case (grant)
                GNT_PIPE: begin
                    rf_we   <= 1'b1;
                    rf_addr <= pipe_addr;
                    rf_data <= pipe_data;
                end
                GNT_AUX: begin
                    rf_we   <= 1'b1;
                    rf_addr <= head.addr;
                    rf_data <= head.data;
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: queue-based model compared every cycle, plus directed literal checks.
module tb_rf_wr_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [3:0]  pipe_addr = '0;
    logic [15:0] pipe_data = '0;
    logic        pipe_stall;
    logic        aux_valid = 1'b0;
    logic [3:0]  aux_addr = '0;
    logic [15:0] aux_data = '0;
    logic        aux_ready;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic [15:0] pend_mask;
    logic [2:0]  aux_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ready(aux_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .pend_mask(pend_mask), .aux_cnt(aux_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve = 0;
    bit          model_ok = 0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_addr = '0;
    logic [15:0] exp_data = '0;

    always @(negedge clk) begin
        int          sz;
        bit          full_m, empty_m, live, waw, stall, aux_g;
        logic [15:0] mask;
        ent_t        e;
        sz      = q.size();
        full_m  = (sz == DEPTH);
        empty_m = (sz == 0);
        mask    = '0;
        foreach (q[i]) mask[q[i].a] = 1'b1;
        live = pipe_we && (pipe_addr != 4'd0);
        waw  = 0;
        foreach (q[i]) if (live && q[i].a == pipe_addr) waw = 1;
        stall = !empty_m && (starve == LIMIT || waw);
        if (model_ok) begin
            check("rf_we",      32'(rf_we),      32'(exp_we));
            check("rf_addr",    32'(rf_addr),    32'(exp_addr));
            check("rf_data",    32'(rf_data),    32'(exp_data));
            check("aux_cnt",    32'(aux_cnt),    32'(sz));
            check("pend_mask",  32'(pend_mask),  32'(mask));
            check("aux_ready",  32'(aux_ready),  32'(!full_m));
            check("pipe_stall", 32'(pipe_stall), 32'(stall));
        end
        if (!rst_n) begin
            q.delete();
            starve   = 0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
            model_ok = 1;
        end else begin
            aux_g = !empty_m && (stall || !live);
            if (aux_g) begin
                exp_we   = 1'b1;
                exp_addr = q[0].a;
                exp_data = q[0].d;
                void'(q.pop_front());
            end else if (live) begin
                exp_we   = 1'b1;
                exp_addr = pipe_addr;
                exp_data = pipe_data;
            end else begin
                exp_we = 1'b0;
            end
            if (empty_m || aux_g) starve = 0;
            else if (starve < LIMIT) starve++;
            if (aux_valid && !full_m && aux_addr != 4'd0) begin
                e.a = aux_addr;
                e.d = aux_data;
                q.push_back(e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_pipe(input logic we, input logic [3:0] a, input logic [15:0] d);
        pipe_we = we; pipe_addr = a; pipe_data = d;
    endtask

    task automatic set_aux(input logic v, input logic [3:0] a, input logic [15:0] d);
        aux_valid = v; aux_addr = a; aux_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        at_neg();
        check("reset_rf_we",     32'(rf_we), 0);
        check("reset_aux_cnt",   32'(aux_cnt), 0);
        check("reset_pend_mask", 32'(pend_mask), 0);
        check("reset_aux_ready", 32'(aux_ready), 1);

        // 1: pipe-only write
        tick();
        set_pipe(1, 4'd3, 16'hBEEF);
        at_neg();
        check("t1_stall", 32'(pipe_stall), 0);
        tick();
        set_pipe(0, 4'd0, 16'h0);
        at_neg();
        check("t1_we",   32'(rf_we), 1);
        check("t1_addr", 32'(rf_addr), 3);
        check("t1_data", 32'(rf_data), 32'hBEEF);

        // 2: queue two aux writes behind a busy pipe, then drain in idle slots
        set_pipe(1, 4'd2, 16'h0002);
        set_aux(1, 4'd5, 16'h1234);
        tick();
        set_aux(1, 4'd6, 16'h5678);
        tick();
        set_aux(0, 4'd0, 16'h0);
        set_pipe(0, 4'd0, 16'h0);
        at_neg();
        check("t2_cnt2",  32'(aux_cnt), 2);
        check("t2_mask2", 32'(pend_mask), 32'h0060);
        tick();
        at_neg();
        check("t2_addr5", 32'(rf_addr), 5);
        check("t2_data5", 32'(rf_data), 32'h1234);
        check("t2_cnt1",  32'(aux_cnt), 1);
        check("t2_mask1", 32'(pend_mask), 32'h0040);
        tick();
        at_neg();
        check("t2_addr6", 32'(rf_addr), 6);
        check("t2_data6", 32'(rf_data), 32'h5678);
        check("t2_cnt0",  32'(aux_cnt), 0);
        check("t2_mask0", 32'(pend_mask), 0);

        // 3: starvation forces one drain after LIMIT pipe wins
        tick();
        set_pipe(1, 4'd1, 16'h1111);
        set_aux(1, 4'd7, 16'h7777);
        tick();
        set_aux(0, 4'd0, 16'h0);
        for (int i = 0; i < LIMIT; i++) begin
            at_neg();
            check("t3_no_stall", 32'(pipe_stall), 0);
            tick();
            check("t3_pipe_addr", 32'(rf_addr), 1);
        end
        at_neg();
        check("t3_stall", 32'(pipe_stall), 1);
        tick();
        at_neg();
        check("t3_aux_addr", 32'(rf_addr), 7);
        check("t3_aux_data", 32'(rf_data), 32'h7777);
        check("t3_resume",   32'(pipe_stall), 0);
        tick();
        at_neg();
        check("t3_pipe_back", 32'(rf_addr), 1);
        set_pipe(0, 4'd0, 16'h0);

        // 4: WAW interlock orders the older aux write first
        tick();
        set_pipe(1, 4'd9, 16'h9999);
        set_aux(1, 4'd4, 16'hAAAA);
        tick();
        set_aux(0, 4'd0, 16'h0);
        set_pipe(1, 4'd4, 16'h5555);
        at_neg();
        check("t4_stall", 32'(pipe_stall), 1);
        tick();
        at_neg();
        check("t4_aux_addr", 32'(rf_addr), 4);
        check("t4_aux_data", 32'(rf_data), 32'hAAAA);
        check("t4_unstall",  32'(pipe_stall), 0);
        tick();
        set_pipe(0, 4'd0, 16'h0);
        at_neg();
        check("t4_pipe_data", 32'(rf_data), 32'h5555);

        // 5: full FIFO, aux R0 discard, pipe R0 gives slot to the FIFO
        tick();
        set_pipe(1, 4'd2, 16'h2222);
        for (int i = 8; i < 12; i++) begin
            set_aux(1, 4'(i), 16'(i * 16'h1111));
            tick();
        end
        set_aux(1, 4'd12, 16'hCCCC);
        at_neg();
        check("t5_full_ready", 32'(aux_ready), 0);
        check("t5_full_cnt",   32'(aux_cnt), 4);
        tick();
        at_neg();
        check("t5_still_full", 32'(aux_cnt), 4);
        set_aux(0, 4'd0, 16'h0);
        set_pipe(1, 4'd0, 16'hFFFF);
        tick();
        at_neg();
        check("t5_r0_slot_addr", 32'(rf_addr), 8);
        check("t5_r0_slot_data", 32'(rf_data), 32'h8888);
        check("t5_r0_slot_cnt",  32'(aux_cnt), 3);
        set_pipe(1, 4'd2, 16'h2222);
        set_aux(1, 4'd0, 16'hDEAD);
        at_neg();
        check("t5_r0_ready", 32'(aux_ready), 1);
        tick();
        set_aux(0, 4'd0, 16'h0);
        set_pipe(0, 4'd0, 16'h0);
        at_neg();
        check("t5_r0_cnt", 32'(aux_cnt), 3);
        repeat (3) tick();
        at_neg();
        check("t5_drained_cnt",  32'(aux_cnt), 0);
        check("t5_drained_addr", 32'(rf_addr), 11);

        // 6: reset with entries queued
        tick();
        set_pipe(1, 4'd2, 16'h2222);
        set_aux(1, 4'd3, 16'h3333); tick();
        set_aux(1, 4'd5, 16'h5555); tick();
        set_aux(1, 4'd6, 16'h6666); tick();
        set_aux(0, 4'd0, 16'h0);
        set_pipe(0, 4'd0, 16'h0);
        at_neg();
        check("t6_cnt3",  32'(aux_cnt), 3);
        check("t6_mask3", 32'(pend_mask), 32'h0068);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        at_neg();
        check("t6_rst_cnt",   32'(aux_cnt), 0);
        check("t6_rst_mask",  32'(pend_mask), 0);
        check("t6_rst_we",    32'(rf_we), 0);
        check("t6_rst_ready", 32'(aux_ready), 1);
        repeat (4) tick();
        at_neg();
        check("t6_no_write", 32'(rf_we), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
